// File: rtl/sprite_blitter_if.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter_if
//  Brief    : Request, descriptor, sprite-ROM and frame-buffer signals of the
//             sprite blitter. The blitter connects as slave, the system as master.
//  Revision : 1.0
// ============================================================================
interface sprite_blitter_if;
    logic               req_valid;
    logic               req_ready;
    logic [5:0]         req_id;
    logic [10:0]        req_x;
    logic [10:0]        req_y;
    logic               req_flip;
    logic [5:0]         obj_id;
    logic [10:0]        obj_h;
    logic [10:0]        obj_w;
    logic [18:0]        obj_addr;
    logic [18:0]        rom_addr;
    logic [11:0]        rom_data;
    logic               fb_we;
    logic [18:0]        fb_addr;
    logic [11:0]        fb_data;
    logic               busy;
    logic               done;

    modport slave (
        input  req_valid, req_id, req_x, req_y, req_flip,
        input  obj_h, obj_w, obj_addr, rom_data,
        output req_ready, obj_id, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );

    modport master (
        output req_valid, req_id, req_x, req_y, req_flip,
        output obj_h, obj_w, obj_addr, rom_data,
        input  req_ready, obj_id, rom_addr, fb_we, fb_addr, fb_data, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_blitter
//  Brief    : Walks a sprite from ROM row by row and writes its opaque,
//             on-screen pixels into the frame buffer.
//  Revision : 1.0
// ============================================================================
module sprite_blitter #(
    parameter int unsigned SCR_W = 640,
    parameter int unsigned SCR_H = 480,
    parameter logic [11:0] TRANS = 12'hF0F
) (
    input  logic            clk,
    input  logic            rst_n,
    sprite_blitter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_RUN    = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    localparam logic signed [12:0] c_scr_w = 13'(SCR_W);
    localparam logic signed [12:0] c_scr_h = 13'(SCR_H);

    state_t             state_q, state_d;
    logic [5:0]         id_q, id_d;
    logic [10:0]        x_q, x_d, y_q, y_d;
    logic               flip_q, flip_d;
    logic [10:0]        h_q, h_d, w_q, w_d;
    logic [18:0]        base_q, base_d;
    logic [10:0]        row_q, row_d, col_q, col_d;
    logic               pend_q, pend_d;
    logic signed [12:0] sx_q, sx_d, sy_q, sy_d;
    logic               done_q, done_d;

    logic               w_last;
    logic [10:0]        w_col_off;
    logic [18:0]        w_row_off;
    logic               w_on;
    logic [18:0]        w_fb_lin;

    assign w_last    = (row_q == h_q - 11'd1) && (col_q == w_q - 11'd1);
    assign w_col_off = flip_q ? (w_q - 11'd1 - col_q) : col_q;
    assign w_row_off = 19'(row_q) * 19'(w_q);

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        x_d     = x_q;
        y_d     = y_q;
        flip_d  = flip_q;
        h_d     = h_q;
        w_d     = w_q;
        base_d  = base_q;
        row_d   = row_q;
        col_d   = col_q;
        pend_d  = 1'b0;
        sx_d    = sx_q;
        sy_d    = sy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    id_d    = bus.req_id;
                    x_d     = bus.req_x;
                    y_d     = bus.req_y;
                    flip_d  = bus.req_flip;
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                h_d    = bus.obj_h;
                w_d    = bus.obj_w;
                base_d = bus.obj_addr;
                row_d  = 11'd0;
                col_d  = 11'd0;
                if (bus.obj_h == 11'd0 || bus.obj_w == 11'd0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Screen position rides one cycle behind the read to meet the ROM data.
                pend_d = 1'b1;
                sx_d   = $signed({{2{x_q[10]}}, x_q}) + $signed({2'b00, col_q});
                sy_d   = $signed({{2{y_q[10]}}, y_q}) + $signed({2'b00, row_q});
                if (col_q == w_q - 11'd1) begin
                    col_d = 11'd0;
                    row_d = row_q + 11'd1;
                end else begin
                    col_d = col_q + 11'd1;
                end
                if (w_last) begin
                    state_d = ST_DRAIN;
                    done_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            flip_q  <= 1'b0;
            h_q     <= '0;
            w_q     <= '0;
            base_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            pend_q  <= 1'b0;
            sx_q    <= '0;
            sy_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            x_q     <= x_d;
            y_q     <= y_d;
            flip_q  <= flip_d;
            h_q     <= h_d;
            w_q     <= w_d;
            base_q  <= base_d;
            row_q   <= row_d;
            col_q   <= col_d;
            pend_q  <= pend_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            done_q  <= done_d;
        end
    end

    assign w_on = pend_q && (bus.rom_data != TRANS) &&
                  (sx_q >= 13'sd0) && (sx_q < c_scr_w) &&
                  (sy_q >= 13'sd0) && (sy_q < c_scr_h);
    assign w_fb_lin = 19'(sy_q) * 19'(SCR_W) + 19'(sx_q);

    assign bus.req_ready = (state_q == ST_IDLE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.obj_id    = id_q;
    assign bus.rom_addr  = (state_q == ST_RUN) ? (base_q + w_row_off + 19'(w_col_off)) : 19'd0;
    assign bus.fb_we     = w_on;
    assign bus.fb_addr   = w_on ? w_fb_lin : 19'd0;
    assign bus.fb_data   = w_on ? bus.rom_data : 12'd0;

endmodule
`default_nettype wire

// File: tb/tb_sprite_blitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_blitter
//  Brief    : Directed, self-checking bench for sprite_blitter.
//  Revision : 1.0
// ============================================================================
module tb_sprite_blitter;

    logic clk;
    logic rst_n;
    sprite_blitter_if bus ();

    sprite_blitter #(.SCR_W(640), .SCR_H(480), .TRANS(12'hF0F)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Descriptor table: id 3 = 16x16 @0x100, id 7 = zero width, id 9 = 2 rows x 3 cols @0x200
    always_comb begin
        bus.obj_h    = 11'd0;
        bus.obj_w    = 11'd0;
        bus.obj_addr = 19'd0;
        case (bus.obj_id)
            6'd3: begin bus.obj_h = 11'd16; bus.obj_w = 11'd16; bus.obj_addr = 19'h100; end
            6'd7: begin bus.obj_h = 11'd4;  bus.obj_w = 11'd0;  bus.obj_addr = 19'h300; end
            6'd9: begin bus.obj_h = 11'd2;  bus.obj_w = 11'd3;  bus.obj_addr = 19'h200; end
            default: ;
        endcase
    end

    // ROM word = low address bits (never the key) unless the transparent mode is selected
    logic rom_trans;
    initial bus.rom_data = 12'd0;
    always @(posedge clk)
        bus.rom_data <= rom_trans ? 12'hF0F : {1'b0, bus.rom_addr[10:0]};

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int acc_cyc, rel;
    int nwr, ndone, nrd, nout, done_rel, first_rel;
    logic [18:0] first_addr, last_addr;
    logic [11:0] first_data, last_data;
    logic rdy2, busy1;
    int clip_xmax, clip_ymin;

    always @(negedge clk) begin
        if (bus.req_valid && bus.req_ready) acc_cyc = cyc;
        rel = cyc - acc_cyc;
        if (bus.fb_we) begin
            nwr = nwr + 1;
            if (nwr == 1) begin
                first_addr = bus.fb_addr;
                first_data = bus.fb_data;
                first_rel  = rel;
            end
            last_addr = bus.fb_addr;
            last_data = bus.fb_data;
            if ((int'(bus.fb_addr) % 640) > clip_xmax || (int'(bus.fb_addr) / 640) < clip_ymin)
                nout = nout + 1;
        end
        if (bus.done) begin
            ndone    = ndone + 1;
            done_rel = rel;
        end
        if (bus.rom_addr != 19'd0) nrd = nrd + 1;
        if (rel == 1) busy1 = bus.busy;
        if (rel == 2) rdy2 = bus.req_ready;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic clear_stats();
        nwr = 0; ndone = 0; nrd = 0; nout = 0; done_rel = -1; first_rel = -1;
        first_addr = '0; last_addr = '0; first_data = '0; last_data = '0;
        rdy2 = 1'b0; busy1 = 1'b0;
    endtask

    task automatic send_req(input logic [5:0] id, input logic [10:0] x,
                            input logic [10:0] y, input logic flip);
        @(posedge clk); #2;
        clear_stats();
        bus.req_id = id; bus.req_x = x; bus.req_y = y; bus.req_flip = flip;
        bus.req_valid = 1'b1;
        @(posedge clk); #2;
        bus.req_valid = 1'b0;
    endtask

    task automatic run_req(input logic [5:0] id, input logic [10:0] x,
                           input logic [10:0] y, input logic flip);
        send_req(id, x, y, flip);
        for (int i = 0; i < 2000 && ndone == 0; i++) @(posedge clk);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        rom_trans = 1'b0;
        bus.req_valid = 1'b0; bus.req_id = '0; bus.req_x = '0; bus.req_y = '0; bus.req_flip = 1'b0;
        acc_cyc = 0; rel = 0; clip_xmax = 639; clip_ymin = 0;
        clear_stats();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",   32'(bus.req_ready), 32'd1);
        chk("rst_busy",    32'(bus.busy),      32'd0);
        chk("rst_done",    32'(bus.done),      32'd0);
        chk("rst_fb_we",   32'(bus.fb_we),     32'd0);
        chk("rst_obj_id",  32'(bus.obj_id),    32'd0);
        chk("rst_rom",     32'(bus.rom_addr),  32'd0);
        chk("rst_fb_addr", 32'(bus.fb_addr),   32'd0);
        chk("rst_fb_data", 32'(bus.fb_data),   32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // 1: opaque 16x16 at (10,20)
        run_req(6'd3, 11'd10, 11'd20, 1'b0);
        chk("t1_ndone",      32'(ndone),      32'd1);
        chk("t1_done_cyc",   32'(done_rel),   32'd258);
        chk("t1_nwr",        32'(nwr),        32'd256);
        chk("t1_first_addr", 32'(first_addr), 32'd12810);
        chk("t1_first_data", 32'(first_data), 32'h100);
        chk("t1_first_cyc",  32'(first_rel),  32'd3);
        chk("t1_last_addr",  32'(last_addr),  32'd22425);
        chk("t1_last_data",  32'(last_data),  32'h1FF);

        // 2: same sprite mirrored
        run_req(6'd3, 11'd10, 11'd20, 1'b1);
        chk("t2_first_addr", 32'(first_addr), 32'd12810);
        chk("t2_first_data", 32'(first_data), 32'h10F);
        chk("t2_last_addr",  32'(last_addr),  32'd22425);
        chk("t2_last_data",  32'(last_data),  32'h1F0);
        chk("t2_done_cyc",   32'(done_rel),   32'd258);

        // 3: clipped at left and bottom edges, placed at (-4,470)
        clip_xmax = 11; clip_ymin = 470;
        run_req(6'd3, 11'h7FC, 11'd470, 1'b0);
        chk("t3_nwr",        32'(nwr),        32'd120);
        chk("t3_out_window", 32'(nout),       32'd0);
        chk("t3_first_addr", 32'(first_addr), 32'd300800);
        chk("t3_first_data", 32'(first_data), 32'h104);
        chk("t3_last_addr",  32'(last_addr),  32'd306571);
        chk("t3_last_data",  32'(last_data),  32'h19F);
        chk("t3_done_cyc",   32'(done_rel),   32'd258);
        clip_xmax = 639; clip_ymin = 0;

        // 4: fully transparent sprite
        rom_trans = 1'b1;
        run_req(6'd3, 11'd10, 11'd20, 1'b0);
        chk("t4_nwr",      32'(nwr),      32'd0);
        chk("t4_ndone",    32'(ndone),    32'd1);
        chk("t4_done_cyc", 32'(done_rel), 32'd258);
        rom_trans = 1'b0;

        // 5: zero-width descriptor
        run_req(6'd7, 11'd10, 11'd20, 1'b0);
        chk("t5_nrd",      32'(nrd),      32'd0);
        chk("t5_nwr",      32'(nwr),      32'd0);
        chk("t5_done_cyc", 32'(done_rel), 32'd2);
        chk("t5_ndone",    32'(ndone),    32'd1);
        chk("t5_ready_c2", 32'(rdy2),     32'd1);
        chk("t5_busy_c1",  32'(busy1),    32'd1);

        // 6: reset while walking the sprite, then a fresh request
        send_req(6'd3, 11'd10, 11'd20, 1'b0);
        repeat (40) @(posedge clk);
        #2;
        chk("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t6_fb_we", 32'(bus.fb_we),     32'd0);
        chk("t6_busy",  32'(bus.busy),      32'd0);
        chk("t6_ready", 32'(bus.req_ready), 32'd1);
        chk("t6_done",  32'(bus.done),      32'd0);
        ndone = 0;
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        chk("t6_no_done", 32'(ndone), 32'd0);
        run_req(6'd9, 11'd100, 11'd50, 1'b0);
        chk("t6_nwr",        32'(nwr),        32'd6);
        chk("t6_done_cyc",   32'(done_rel),   32'd8);
        chk("t6_first_addr", 32'(first_addr), 32'd32100);
        chk("t6_first_data", 32'(first_data), 32'h200);
        chk("t6_last_addr",  32'(last_addr),  32'd32742);
        chk("t6_last_data",  32'(last_data),  32'h205);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
